// File: rtl/function_table_inverter.sv
// Inverse lookup for a registered, monotonic non-decreasing function table.
// Bitwise binary search over x: finds the smallest x with f(x) >= target by
// probing the table through oTabX/iTabY, then re-probes the result to report
// whether the match is exact.
module function_table_inverter #(
  parameter int unsigned WIDTH_X       = 10,
  parameter int unsigned WIDTH_Y       = 8,
  parameter int unsigned TABLE_LATENCY = 1
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iValid,
  output logic               oReady,
  input  logic [WIDTH_Y-1:0] iTarget,
  output logic               oValid,
  input  logic               iReady,
  output logic [WIDTH_X-1:0] oX,
  output logic               oExact,
  output logic [WIDTH_X-1:0] oTabX,
  input  logic [WIDTH_Y-1:0] iTabY
);

  localparam int unsigned KW = (WIDTH_X > 1) ? $clog2(WIDTH_X) : 1;
  localparam int unsigned CW = (TABLE_LATENCY > 1) ? $clog2(TABLE_LATENCY) : 1;
  localparam logic [KW-1:0] KTop = KW'(WIDTH_X - 1);
  localparam logic [CW-1:0] WaitLast = CW'(TABLE_LATENCY - 1);
  localparam logic [WIDTH_X-1:0] MsbOnly = {1'b1, {(WIDTH_X-1){1'b0}}};
  localparam logic [WIDTH_X-1:0] LsbOnly = {{(WIDTH_X-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StVerifyIssue,
    StWaitV,
    StDone
  } state_t;

  state_t state;

  // r is an offset code (x + 2^(WIDTH_X-1)); it ends as the count of codes whose
  // table value is below target, i.e. the code of the smallest satisfying x.
  logic [WIDTH_X-1:0] r;
  logic [KW-1:0]      k;
  logic [CW-1:0]      waitCnt;
  logic [WIDTH_Y-1:0] target;

  logic [WIDTH_X-1:0] probeT;
  logic               below;
  logic [WIDTH_X-1:0] rAfter;
  logic [KW-1:0]      kDec;
  logic [WIDTH_X-1:0] nextT;
  logic [WIDTH_X-1:0] firstProbe;

  // Offset code to two's complement: flip the MSB.
  function automatic logic [WIDTH_X-1:0] offsetDecode(input logic [WIDTH_X-1:0] u);
    return u ^ MsbOnly;
  endfunction

  // Probe candidates and the compare result for the current step.
  always_comb begin
    probeT     = r | (LsbOnly << k);
    below      = $signed(iTabY) < $signed(target);
    rAfter     = below ? probeT : r;
    kDec       = k - KW'(1);
    nextT      = rAfter | (LsbOnly << kDec);
    firstProbe = offsetDecode(MsbOnly - LsbOnly);
  end

  // Search FSM; oTabX is loaded on the edge entering an issue state so the
  // address is already stable during the issue cycle.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= StIdle;
      r       <= '0;
      k       <= KTop;
      waitCnt <= '0;
      target  <= '0;
      oReady  <= 1'b1;
      oValid  <= 1'b0;
      oX      <= '0;
      oExact  <= 1'b0;
      oTabX   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (iValid && oReady) begin
            target <= iTarget;
            r      <= '0;
            k      <= KTop;
            oTabX  <= firstProbe;
            oReady <= 1'b0;
            state  <= StIssue;
          end
        end
        StIssue: begin
          waitCnt <= WaitLast;
          state   <= StWait;
        end
        StWait: begin
          if (waitCnt != '0) begin
            waitCnt <= waitCnt - CW'(1);
          end else begin
            r <= rAfter;
            if (k == '0) begin
              oTabX <= offsetDecode(rAfter);
              state <= StVerifyIssue;
            end else begin
              k     <= kDec;
              oTabX <= offsetDecode(nextT - LsbOnly);
              state <= StIssue;
            end
          end
        end
        StVerifyIssue: begin
          waitCnt <= WaitLast;
          state   <= StWaitV;
        end
        StWaitV: begin
          if (waitCnt != '0) begin
            waitCnt <= waitCnt - CW'(1);
          end else begin
            oX     <= offsetDecode(r);
            oExact <= (iTabY == target);
            oValid <= 1'b1;
            state  <= StDone;
          end
        end
        StDone: begin
          if (iReady) begin
            oValid <= 1'b0;
            oReady <= 1'b1;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
